// File: rtl/stopwatch_ctrl_if.sv
// Stopwatch controller signal bundle: key pulses, timer tick/value in,
// timer control and display values out.
interface stopwatch_ctrl_if #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 20
);
  localparam int unsigned LW = $clog2(DEPTH);

  logic          key_start;
  logic          key_interval;
  logic          key_clear;
  logic          time_1ms;
  logic [W-1:0]  t;

  logic          run_en;
  logic          timer_clr;
  logic [W-1:0]  disp_time;
  logic [W-1:0]  disp_delta;
  logic [LW:0]   lap_count;
  logic [LW-1:0] lap_idx;
  logic          ovf;
  logic          blink;
  logic [1:0]    state_o;

  // Environment side: drives keys, tick and live timer value.
  modport master (
    output key_start, key_interval, key_clear, time_1ms, t,
    input  run_en, timer_clr, disp_time, disp_delta, lap_count, lap_idx,
           ovf, blink, state_o
  );

  // Controller side.
  modport slave (
    input  key_start, key_interval, key_clear, time_1ms, t,
    output run_en, timer_clr, disp_time, disp_delta, lap_count, lap_idx,
           ovf, blink, state_o
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: start/stop, lap capture into a small buffer,
// lap review with split display, clear, and pause blink generation.
// DEPTH must be a power of two, at least 2.
module stopwatch_ctrl #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 20
) (
  input  logic          clk,
  input  logic          KEY2,
  stopwatch_ctrl_if.slave sw
);
  localparam int unsigned LW = $clog2(DEPTH);
  localparam logic [LW:0] FULL = (LW+1)'(DEPTH);
  localparam logic [8:0]  BLINK_LAST = 9'd499;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    PAUSE  = 2'b10,
    REVIEW = 2'b11
  } state_t;

  logic [1:0]    rst_sync;
  logic          rst_n;

  state_t        state_q, state_d;
  logic [LW:0]   lap_count_q, lap_count_d;
  logic [LW-1:0] lap_idx_q, lap_idx_d;
  logic          ovf_q, ovf_d;
  logic          blink_q, blink_d;
  logic [8:0]    blink_cnt_q, blink_cnt_d;
  logic          run_en_q, timer_clr_q;
  logic          clr_acc, wr_en;
  logic [W-1:0]  disp_time_q, disp_delta_q, disp_delta_d;
  logic [LW-1:0] prev_idx;
  logic [W-1:0]  buffer [DEPTH];

  // Reset asserts asynchronously but is released only after two clk edges.
  always_ff @(posedge clk or negedge KEY2) begin
    if (!KEY2) rst_sync <= '0;
    else       rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  // Next state, lap bookkeeping and blink; key_clear > key_start > key_interval,
  // where a key that means nothing in the current state does not mask lower ones.
  always_comb begin
    state_d      = state_q;
    lap_count_d  = lap_count_q;
    lap_idx_d    = lap_idx_q;
    ovf_d        = ovf_q;
    clr_acc      = 1'b0;
    wr_en        = 1'b0;
    blink_d      = blink_q;
    blink_cnt_d  = blink_cnt_q;
    disp_delta_d = '0;
    prev_idx     = '0;

    unique case (state_q)
      IDLE: begin
        if (sw.key_start) state_d = RUN;
      end
      RUN: begin
        if (sw.key_start) begin
          state_d = PAUSE;
        end else if (sw.key_interval) begin
          if (lap_count_q == FULL) begin
            ovf_d = 1'b1;
          end else begin
            wr_en       = 1'b1;
            lap_count_d = lap_count_q + (LW+1)'(1);
          end
        end
      end
      PAUSE: begin
        if (sw.key_clear) begin
          clr_acc = 1'b1;
        end else if (sw.key_start) begin
          state_d = RUN;
        end else if (sw.key_interval && lap_count_q != '0) begin
          state_d   = REVIEW;
          lap_idx_d = '0;
        end
      end
      REVIEW: begin
        if (sw.key_clear) begin
          clr_acc = 1'b1;
        end else if (sw.key_start) begin
          state_d = PAUSE;
        end else if (sw.key_interval) begin
          if ((LW+1)'(lap_idx_q) + (LW+1)'(1) == lap_count_q) lap_idx_d = '0;
          else                                                 lap_idx_d = lap_idx_q + LW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (clr_acc) begin
      state_d     = IDLE;
      lap_count_d = '0;
      lap_idx_d   = '0;
      ovf_d       = 1'b0;
    end

    // Blink counter runs only while staying in PAUSE; entry or exit restarts it.
    if (state_d != PAUSE || state_q != PAUSE) begin
      blink_d     = 1'b0;
      blink_cnt_d = '0;
    end else if (sw.time_1ms) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 9'd1;
      end
    end

    prev_idx = lap_idx_d - LW'(1);
    if (state_d == REVIEW) begin
      if (lap_idx_d == '0) disp_delta_d = buffer[lap_idx_d];
      else                 disp_delta_d = buffer[lap_idx_d] - buffer[prev_idx];
    end
  end

  // Control/status registers, cleared immediately by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      lap_count_q  <= '0;
      lap_idx_q    <= '0;
      ovf_q        <= 1'b0;
      blink_q      <= 1'b0;
      blink_cnt_q  <= '0;
      run_en_q     <= 1'b0;
      timer_clr_q  <= 1'b0;
      disp_delta_q <= '0;
    end else begin
      state_q      <= state_d;
      lap_count_q  <= lap_count_d;
      lap_idx_q    <= lap_idx_d;
      ovf_q        <= ovf_d;
      blink_q      <= blink_d;
      blink_cnt_q  <= blink_cnt_d;
      run_en_q     <= (state_d == RUN);
      timer_clr_q  <= clr_acc;
      disp_delta_q <= disp_delta_d;
    end
  end

  // Lap storage; contents are only visible through indices below lap_count.
  always_ff @(posedge clk) begin
    if (wr_en) buffer[lap_count_q[LW-1:0]] <= sw.t;
  end

  // Display value: stored lap under review, live timer otherwise (also in reset,
  // since the FSM then sits in IDLE).
  always_ff @(posedge clk) begin
    if (state_d == REVIEW) disp_time_q <= buffer[lap_idx_d];
    else                   disp_time_q <= sw.t;
  end

  assign sw.state_o    = state_q;
  assign sw.run_en     = run_en_q;
  assign sw.timer_clr  = timer_clr_q;
  assign sw.lap_count  = lap_count_q;
  assign sw.lap_idx    = lap_idx_q;
  assign sw.ovf        = ovf_q;
  assign sw.blink      = blink_q;
  assign sw.disp_time  = disp_time_q;
  assign sw.disp_delta = disp_delta_q;
endmodule
